au: RTL and testbench

AU -- requirements
Module: au

---
 rtl/au.sv | 118 +++++++++++
 tb/tb_au.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/au.sv
// Arithmetic unit: 3-bit add/subtract (unsigned or signed) with overflow flag
// and magnitude compare of a against b, all registered with one-cycle latency.
// Optional feature: define AU_SAT_EN to saturate y whenever ov is set.
module au (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [1:0] op,
  output logic [2:0] y,
  output logic       ov,
  output logic       gt,
  output logic       lt,
  output logic       eq,
  output logic       out_valid
);

  typedef enum logic [1:0] {
    OP_ADDU = 2'b00,
    OP_SUBU = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  op_e        op_s;
  logic [3:0] sum;
  logic [3:0] dif;
  logic [2:0] y_d, y_q;
  logic       ov_d, ov_q;
  logic       gt_d, gt_q;
  logic       lt_d, lt_q;
  logic       eq_d, eq_q;
  logic       vld_q;

  assign op_s = op_e'(op);

  // Combinational result, overflow and compare flags for the sampled operands.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    dif  = {1'b0, a} - {1'b0, b};
    y_d  = '0;
    ov_d = 1'b0;
    case (op_s)
      OP_ADDU: begin
        y_d  = sum[2:0];
        ov_d = sum[3];
      end
      OP_SUBU: begin
        // bit 3 of the zero-extended difference is the borrow (a < b)
        y_d  = dif[2:0];
        ov_d = dif[3];
      end
      OP_ADD: begin
        y_d  = sum[2:0];
        ov_d = (a[2] == b[2]) && (sum[2] != a[2]);
      end
      OP_SUB: begin
        y_d  = dif[2:0];
        ov_d = (a[2] != b[2]) && (dif[2] != a[2]);
      end
      default: begin
        y_d  = '0;
        ov_d = 1'b0;
      end
    endcase

`ifdef AU_SAT_EN
    // Clamp to the range limit in the direction of the overflow; for signed ops
    // the sign of a tells which end was exceeded.
    if (ov_d) begin
      case (op_s)
        OP_ADDU: y_d = 3'b111;
        OP_SUBU: y_d = 3'b000;
        default: y_d = a[2] ? 3'b100 : 3'b011;
      endcase
    end
`endif

    eq_d = (a == b);
    if (op[1]) begin
      lt_d = ($signed(a) < $signed(b));
      gt_d = ($signed(a) > $signed(b));
    end else begin
      lt_d = (a < b);
      gt_d = (a > b);
    end
  end

  // Output registers: clear on reset, load on in_valid, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      ov_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        y_q  <= y_d;
        ov_q <= ov_d;
        gt_q <= gt_d;
        lt_q <= lt_d;
        eq_q <= eq_d;
      end
    end
  end

  assign y         = y_q;
  assign ov        = ov_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_au.sv
// Directed self-checking bench for au; expected values come from constants and
// an integer reference model. Honours AU_SAT_EN for saturated y values.
module tb_au;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] op;
  logic [2:0] y;
  logic       ov;
  logic       gt;
  logic       lt;
  logic       eq;
  logic       out_valid;

  int n_checks = 0;
  int n_errors = 0;

  au dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .y         (y),
    .ov        (ov),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Integer reference model, written from the arithmetic definitions.
  task automatic model(input int aa, input int bb, input int oo,
                       output int ey, output int eov,
                       output int egt, output int elt, output int eeq);
    int sa, sb, r, ca, cb;
    sa = (aa >= 4) ? aa - 8 : aa;
    sb = (bb >= 4) ? bb - 8 : bb;
    case (oo)
      0: r = aa + bb;
      1: r = aa - bb;
      2: r = sa + sb;
      default: r = sa - sb;
    endcase
    if (oo == 0)      eov = (r > 7) ? 1 : 0;
    else if (oo == 1) eov = (r < 0) ? 1 : 0;
    else              eov = (r > 3 || r < -4) ? 1 : 0;
    ey = (r + 16) % 8;
`ifdef AU_SAT_EN
    if (eov == 1) begin
      if (oo == 0)      ey = 7;
      else if (oo == 1) ey = 0;
      else              ey = (r > 3) ? 3 : 4;
    end
`endif
    ca = (oo >= 2) ? sa : aa;
    cb = (oo >= 2) ? sb : bb;
    egt = (ca > cb) ? 1 : 0;
    elt = (ca < cb) ? 1 : 0;
    eeq = (ca == cb) ? 1 : 0;
  endtask

  task automatic drive(input logic [2:0] aa, input logic [2:0] bb,
                       input logic [1:0] oo, input logic v);
    a = aa; b = bb; op = oo; in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ey, input int eov,
                           input int egt, input int elt, input int eeq, input int evld);
    check({tag, ".y"},   8'(y),         8'(ey));
    check({tag, ".ov"},  8'(ov),        8'(eov));
    check({tag, ".gt"},  8'(gt),        8'(egt));
    check({tag, ".lt"},  8'(lt),        8'(elt));
    check({tag, ".eq"},  8'(eq),        8'(eeq));
    check({tag, ".vld"}, 8'(out_valid), 8'(evld));
  endtask

  int ey, eov, egt, elt, eeq;

  initial begin
    rst = 1'b1;
    drive(3'b011, 3'b001, 2'b00, 1'b1);
    step();
    step();
    check_all("reset", 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    // ADDU 5+5
    drive(3'b101, 3'b101, 2'b00, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("addu_5_5", 7, 1, 0, 0, 1, 1);
`else
    check_all("addu_5_5", 2, 1, 0, 0, 1, 1);
`endif
    // SUBU 2-3
    drive(3'b010, 3'b011, 2'b01, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("subu_2_3", 0, 1, 0, 1, 0, 1);
`else
    check_all("subu_2_3", 7, 1, 0, 1, 0, 1);
`endif
    // ADD 3+2 signed
    drive(3'b011, 3'b010, 2'b10, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("add_3_2", 3, 1, 1, 0, 0, 1);
`else
    check_all("add_3_2", 5, 1, 1, 0, 0, 1);
`endif
    // ADD -4 + -3 signed
    drive(3'b100, 3'b101, 2'b10, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("add_m4_m3", 4, 1, 0, 1, 0, 1);
`else
    check_all("add_m4_m3", 1, 1, 0, 1, 0, 1);
`endif
    // SUB 2 - (-3) signed
    drive(3'b010, 3'b101, 2'b11, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("sub_2_m3", 3, 1, 1, 0, 0, 1);
`else
    check_all("sub_2_m3", 5, 1, 1, 0, 0, 1);
`endif
    // SUBU 2 - 5 unsigned
    drive(3'b010, 3'b101, 2'b01, 1'b1); step();
`ifdef AU_SAT_EN
    check_all("subu_2_5", 0, 1, 0, 1, 0, 1);
`else
    check_all("subu_2_5", 5, 1, 0, 1, 0, 1);
`endif

    // Back-to-back sweep against the reference model.
    for (int o = 0; o < 4; o++) begin
      for (int ia = 2; ia <= 5; ia++) begin
        for (int ib = 2; ib <= 5; ib++) begin
          drive(3'(ia), 3'(ib), 2'(o), 1'b1);
          step();
          model(ia, ib, o, ey, eov, egt, elt, eeq);
          check_all($sformatf("sweep_op%0d_a%0d_b%0d", o, ia, ib), ey, eov, egt, elt, eeq, 1);
          check("sweep_onehot", 8'({2'b0, gt} + {2'b0, lt} + {2'b0, eq}), 8'd1);
        end
      end
    end

    // Mid-stream reset for one cycle, in_valid still high.
    drive(3'b001, 3'b010, 2'b00, 1'b1);
    rst = 1'b1;
    step();
    check_all("midrst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(3'b001, 3'b010, 2'b00, 1'b0);
    step();
    check_all("post_rst_idle", 0, 0, 0, 0, 0, 0);

    // First valid after reset: ADDU 1+2 = 3.
    drive(3'b001, 3'b010, 2'b00, 1'b1); step();
    check_all("first_after_rst", 3, 0, 0, 1, 0, 1);

    // in_valid low with different operands: outputs hold, out_valid drops.
    drive(3'b111, 3'b111, 2'b00, 1'b0); step();
    check_all("hold1", 3, 0, 0, 1, 0, 0);
    drive(3'b100, 3'b001, 2'b11, 1'b0); step();
    check_all("hold2", 3, 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
